pe_conv_sequencer: RTL

PE_CONV_SEQUENCER -- requirements
Module: pe_conv_sequencer

---
 rtl/pe_conv_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer: walks a 3x3 kernel over a 4x4 image and accumulates four 2x2 valid-convolution results.
// Build option: define PE_SEQ_REG_IN_EN to register a_in/b_in one stage before the multiplier.
module pe_conv_sequencer (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic [3:0]  s0,
    output logic [3:0]  s1,
    output logic        busy,
    output logic        done,
    output logic [19:0] c11,
    output logic [19:0] c12,
    output logic [19:0] c21,
    output logic [19:0] c22
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t      r_state;
    logic [1:0]  r_o, r_kr, r_kc;
    logic [19:0] r_acc;
    logic [19:0] r_c [4];
    logic        w_last_tap, w_last;
    logic [1:0]  w_o_n, w_kr_n, w_kc_n;
    logic [15:0] w_prod;
    logic [19:0] w_sum;
    logic        w_en, w_tap8;
    logic [1:0]  w_wo;

    assign w_last_tap = (r_kr == 2'd2) && (r_kc == 2'd2);
    assign w_last     = w_last_tap && (r_o == 2'd3);
    assign w_kc_n     = (r_kc == 2'd2) ? 2'd0 : r_kc + 2'd1;
    assign w_kr_n     = (r_kc == 2'd2) ? ((r_kr == 2'd2) ? 2'd0 : r_kr + 2'd1) : r_kr;
    assign w_o_n      = w_last_tap ? r_o + 2'd1 : r_o;
    assign w_sum      = r_acc + {4'd0, w_prod};
    assign c11 = r_c[0];
    assign c12 = r_c[1];
    assign c21 = r_c[2];
    assign c22 = r_c[3];

    // Sequencer FSM: tap counters plus registered selects and status flags
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
            r_o     <= 2'd0;
            r_kr    <= 2'd0;
            r_kc    <= 2'd0;
            s0      <= 4'd0;
            s1      <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    busy    <= 1'b1;
                    r_o     <= 2'd0;
                    r_kr    <= 2'd0;
                    r_kc    <= 2'd0;
                    s0      <= 4'd0;
                    s1      <= 4'd0;
                end
                RUN: if (w_last) begin
                    s0 <= 4'd0;
                    s1 <= 4'd0;
`ifdef PE_SEQ_REG_IN_EN
                    r_state <= DRAIN;
`else
                    r_state <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
`endif
                end else begin
                    r_o  <= w_o_n;
                    r_kr <= w_kr_n;
                    r_kc <= w_kc_n;
                    s0   <= {{1'b0, w_o_n[1]} + w_kr_n, {1'b0, w_o_n[0]} + w_kc_n};
                    s1   <= {w_kr_n, w_kc_n};
                end
                DRAIN: begin
                    r_state <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_SEQ_REG_IN_EN
    logic [7:0] r_a, r_b;
    logic       r_acc_en, r_tap8;
    logic [1:0] r_wo;

    // Operand and control pipeline stage so accumulation trails selection by one cycle
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_acc_en <= 1'b0;
            r_tap8   <= 1'b0;
            r_wo     <= 2'd0;
        end else begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_acc_en <= (r_state == RUN);
            r_tap8   <= w_last_tap;
            r_wo     <= r_o;
        end
    end

    assign w_prod = r_a * r_b;
    assign w_en   = r_acc_en;
    assign w_tap8 = r_tap8;
    assign w_wo   = r_wo;
`else
    assign w_prod = a_in * b_in;
    assign w_en   = (r_state == RUN);
    assign w_tap8 = w_last_tap;
    assign w_wo   = r_o;
`endif

    // Multiply-accumulate; the ninth tap commits the sum and clears the accumulator
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_acc <= 20'd0;
            for (int i = 0; i < 4; i++) r_c[i] <= 20'd0;
        end else if (w_en) begin
            if (w_tap8) begin
                r_acc     <= 20'd0;
                r_c[w_wo] <= w_sum;
            end else begin
                r_acc <= w_sum;
            end
        end
    end
endmodule
